ir_nec_transmitter: RTL and testbench
=====================================

# ir_nec_transmitter

NEC-protocol infrared transmitter, the outbound counterpart of the existing IR receive path (IRController and the regIRHigh/regIRLow registers). It accepts a 32-bit code or a repeat request from the CPU bus side and drives a carrier-modulated IR LED output plus the unmodulated envelope. It sits in MainDesign next to the receiver. The bus logic maps two new RAM-window addresses onto it; that mapping is out of scope here.

## Interface
- UNIT_CYCLES, 28125: clk cycles per NEC unit (562.5 µs at 50 MHz).
- CARRIER_PERIOD, 1316: clk cycles per carrier period (≈38 kHz).
- CARRIER_HIGH, 439: cycles the carrier is high per period (≈1/3 duty); must satisfy 0 < CARRIER_HIGH < CARRIER_PERIOD.
- clk  in  1  system clock, single clock domain.
- res  in  1  reset, synchronous, active-high (top level drives ~res, as it does for IRController).
- start  in  1  one-cycle request to send a full frame.
- repeatReq  in  1  one-cycle request to send an NEC repeat code.
- code  in  32  frame payload, sampled only on the accepting edge.
- busy  out  1  high while a frame is being emitted.
- done  out  1  one-cycle pulse when a frame completes.
- envelope  out  1  unmodulated mark (1) / space (0).
- irOut  out  1  envelope AND carrier; drives the LED.

## Operation
- States: IDLE, LEAD_MARK (16 units), LEAD_SPACE (8 units), REP_SPACE (4 units), BIT_MARK (1 unit), BIT_SPACE (1 unit for 0, 3 units for 1), STOP_MARK (1 unit).
- IDLE, start=1: latch code, bitIdx=0, go to LEAD_MARK. Else if repeatReq=1: set repeat flag, go to LEAD_MARK. start wins when both are high.
- LEAD_MARK goes to LEAD_SPACE, or to REP_SPACE if the repeat flag is set.
- LEAD_SPACE goes to BIT_MARK. BIT_MARK goes to BIT_SPACE.
- BIT_SPACE: if bitIdx=31, go to STOP_MARK; else bitIdx+1 and go to BIT_MARK.
- REP_SPACE goes to STOP_MARK. STOP_MARK goes to IDLE.
- Bit order: code[0] first, code[31] last (LSB-first, NEC byte order address, ~address, command, ~command). The block does no inversion or checking of the payload.
- envelope=1 in *_MARK states, 0 otherwise.
- Carrier counter resets to 0 on entry to every mark state and wraps at CARRIER_PERIOD-1. The carrier is high while counter < CARRIER_HIGH.
- start/repeatReq while busy=1 are ignored; no queueing.

## Timing
- Accepting edge k: at k the code is latched. From after edge k, busy=1, envelope=1, irOut=1, carrier phase 0.
- Each segment lasts exactly n×UNIT_CYCLES cycles.
- busy stays high for exactly U×UNIT_CYCLES cycles:
  - Full frame: U = 16+8+Σ(2 or 4 per bit)+1, i.e. 89 units for all-zero code, 153 for all-one code.
  - Repeat: U = 21.
- On the edge ending STOP_MARK: busy→0, envelope→0, irOut→0, done→1 for one cycle. A new start is accepted in that done cycle.
- Reset values, and values after any edge with res=1, including mid-frame: state IDLE, busy=0, done=0, envelope=0, irOut=0, all counters 0. No partial frame resumes.
- Widths: unit counter ⌈log2 UNIT_CYCLES⌉ bits (15 by default), segment-unit counter 5 bits (max 16), bitIdx 5 bits, carrier counter ⌈log2 CARRIER_PERIOD⌉ bits (11 by default). No counter wraps except the carrier counter.

## Structure
- Shared package ir_nec_pkg: state enum, unit-count constants (LEAD_MARK_U=16, LEAD_SPACE_U=8, REP_SPACE_U=4, BIT_MARK_U=1, ZERO_SPACE_U=1, ONE_SPACE_U=3, STOP_U=1), and default timing parameters. The receiver uses the same constants.
- One sub-module: ir_carrier_gen (parameters CARRIER_PERIOD, CARRIER_HIGH; inputs clk, res, restart; output carrier).
- FSM, unit timing, and payload shift stay in ir_nec_transmitter.

## Test plan
Simulate with UNIT_CYCLES=10, CARRIER_PERIOD=4, CARRIER_HIGH=1.
- code=0x00000000, start pulse → busy high exactly 890 cycles. Envelope shows 160 high, 80 low, then 32× (10 high, 10 low), then 10 high. done pulses once.
- code=0xFFFFFFFF → busy 1530 cycles, every bit space 30 cycles. code=0x00000001 → first bit space 30 cycles, the rest 10.
- repeatReq pulse → envelope 160 high, 40 low, 10 high. busy 210 cycles.
- start and repeatReq in the same cycle → full frame (890 cycles for code 0). start pulses at cycles 100 and 500 into a frame → ignored, frame length unchanged.
- res asserted at cycle 300 of a frame → next cycle busy=0, irOut=0, envelope=0, done=0. A start two cycles later produces a clean 890-cycle frame.
- During any mark, irOut repeats 1,0,0,0 from the first mark cycle. irOut=0 throughout all spaces and IDLE.

Source files
------------

// File: rtl/ir_nec_pkg.sv
// ir_nec_pkg: constants and types shared by the NEC IR transmit path (and the
// receive path). Holds the FSM state enum, segment lengths in NEC units, the
// default timing parameters and two small helpers used by the transmitter FSM.
package ir_nec_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LEAD_MARK  = 3'd1,
        LEAD_SPACE = 3'd2,
        REP_SPACE  = 3'd3,
        BIT_MARK   = 3'd4,
        BIT_SPACE  = 3'd5,
        STOP_MARK  = 3'd6
    } ir_nec_state_e;

    // Segment lengths in NEC units (1 unit = 562.5 us).
    localparam int LEAD_MARK_U  = 16;
    localparam int LEAD_SPACE_U = 8;
    localparam int REP_SPACE_U  = 4;
    localparam int BIT_MARK_U   = 1;
    localparam int ZERO_SPACE_U = 1;
    localparam int ONE_SPACE_U  = 3;
    localparam int STOP_U       = 1;

    // Default timing for a 50 MHz clock.
    localparam int DEF_UNIT_CYCLES    = 28125;
    localparam int DEF_CARRIER_PERIOD = 1316;
    localparam int DEF_CARRIER_HIGH   = 439;

    // Length in units of the segment emitted in state st; bit_val is the
    // payload bit currently being sent (only matters in BIT_SPACE).
    function automatic logic [4:0] seg_units(ir_nec_state_e st, logic bit_val);
        logic [4:0] u;
        u = 5'd1;
        case (st)
            LEAD_MARK:  u = 5'(LEAD_MARK_U);
            LEAD_SPACE: u = 5'(LEAD_SPACE_U);
            REP_SPACE:  u = 5'(REP_SPACE_U);
            BIT_MARK:   u = 5'(BIT_MARK_U);
            BIT_SPACE:  u = bit_val ? 5'(ONE_SPACE_U) : 5'(ZERO_SPACE_U);
            STOP_MARK:  u = 5'(STOP_U);
            default:    u = 5'd1;
        endcase
        return u;
    endfunction

    function automatic logic is_mark(ir_nec_state_e st);
        return (st == LEAD_MARK) || (st == BIT_MARK) || (st == STOP_MARK);
    endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// ir_carrier_gen: free-running carrier for IR marks.
// Ports:
//   clk     - system clock
//   res     - synchronous active-high reset (counter to 0)
//   restart - forces the counter to 0 on the next edge (phase 0 at mark start)
//   carrier - high while the phase counter is below CARRIER_HIGH
module ir_carrier_gen #(
    parameter int CARRIER_PERIOD = 1316,
    parameter int CARRIER_HIGH   = 439
) (
    input  logic clk,
    input  logic res,
    input  logic restart,
    output logic carrier
);

    localparam int CW = (CARRIER_PERIOD > 1) ? $clog2(CARRIER_PERIOD) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (res || restart) begin
            cnt <= '0;
        end else if (cnt == CW'(CARRIER_PERIOD - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign carrier = (cnt < CW'(CARRIER_HIGH));

endmodule

// File: rtl/ir_nec_transmitter.sv
// ir_nec_transmitter: NEC-protocol IR transmitter (full frames and repeat codes).
// Ports:
//   clk, res   - system clock, synchronous active-high reset
//   start      - one-cycle request to send a full 32-bit frame
//   repeatReq  - one-cycle request to send a repeat code
//   code       - payload, LSB sent first, sampled on the accepting edge only
//   busy       - high while a frame is being emitted
//   done       - one-cycle pulse after the final stop mark
//   envelope   - unmodulated mark/space
//   irOut      - envelope gated by the carrier, drives the LED
//   state_dbg  - current FSM state for observation
//
// Handshake: start/repeatReq act as valid strobes and ~busy acts as ready.
// A request is accepted on an edge where busy=0 (start taking priority);
// requests seen while busy=1 are dropped, nothing is queued.
module ir_nec_transmitter
    import ir_nec_pkg::*;
#(
    parameter int UNIT_CYCLES    = DEF_UNIT_CYCLES,
    parameter int CARRIER_PERIOD = DEF_CARRIER_PERIOD,
    parameter int CARRIER_HIGH   = DEF_CARRIER_HIGH
) (
    input  logic          clk,
    input  logic          res,
    input  logic          start,
    input  logic          repeatReq,
    input  logic [31:0]   code,
    output logic          busy,
    output logic          done,
    output logic          envelope,
    output logic          irOut,
    output ir_nec_state_e state_dbg
);

    localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);

    ir_nec_state_e state, state_next;
    logic [UW-1:0] unit_cnt;   // clk cycles within the current unit
    logic [4:0]    seg_cnt;    // whole units elapsed in the current segment
    logic [4:0]    bit_idx;
    logic [31:0]   code_sr;    // bit 0 is the bit currently on the air
    logic          rep_flag;
    logic          seg_end;
    logic          restart;
    logic          carrier;

    // Next-state logic. restart realigns the carrier whenever a mark begins,
    // so every mark starts with a full high phase.
    always_comb begin
        state_next = state;
        seg_end    = (unit_cnt == UNIT_LAST) &&
                     (seg_cnt == (seg_units(state, code_sr[0]) - 5'd1));
        case (state)
            IDLE:       if (start || repeatReq) state_next = LEAD_MARK;
            LEAD_MARK:  if (seg_end) state_next = rep_flag ? REP_SPACE : LEAD_SPACE;
            LEAD_SPACE: if (seg_end) state_next = BIT_MARK;
            REP_SPACE:  if (seg_end) state_next = STOP_MARK;
            BIT_MARK:   if (seg_end) state_next = BIT_SPACE;
            BIT_SPACE:  if (seg_end) state_next = (bit_idx == 5'd31) ? STOP_MARK : BIT_MARK;
            STOP_MARK:  if (seg_end) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
        restart = is_mark(state_next) && (state_next != state);
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state    <= IDLE;
            unit_cnt <= '0;
            seg_cnt  <= '0;
            bit_idx  <= '0;
            code_sr  <= '0;
            rep_flag <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state == STOP_MARK) && seg_end;
            if (state == IDLE) begin
                unit_cnt <= '0;
                seg_cnt  <= '0;
                if (start) begin
                    code_sr  <= code;
                    bit_idx  <= '0;
                    rep_flag <= 1'b0;
                end else if (repeatReq) begin
                    rep_flag <= 1'b1;
                end
            end else begin
                if (unit_cnt == UNIT_LAST) begin
                    unit_cnt <= '0;
                    seg_cnt  <= seg_end ? 5'd0 : seg_cnt + 5'd1;
                end else begin
                    unit_cnt <= unit_cnt + 1'b1;
                end
                if ((state == BIT_SPACE) && seg_end && (bit_idx != 5'd31)) begin
                    bit_idx <= bit_idx + 5'd1;
                    code_sr <= {1'b0, code_sr[31:1]};
                end
            end
        end
    end

    ir_carrier_gen #(
        .CARRIER_PERIOD (CARRIER_PERIOD),
        .CARRIER_HIGH   (CARRIER_HIGH)
    ) u_carrier (
        .clk     (clk),
        .res     (res),
        .restart (restart),
        .carrier (carrier)
    );

    assign busy      = (state != IDLE);
    assign envelope  = is_mark(state);
    assign irOut     = envelope & carrier;
    assign state_dbg = state;

endmodule

// File: tb/tb_ir_nec_transmitter.sv
// Bench for ir_nec_transmitter with short timing (10-cycle unit, 4-cycle
// carrier, 1 cycle high). Expected waveforms are built from the NEC segment
// rules as a per-cycle queue of {envelope, irOut}.
module tb_ir_nec_transmitter;

  localparam int U  = 10;
  localparam int CP = 4;
  localparam int CH = 1;

  logic        clk;
  logic        res;
  logic        start;
  logic        repeatReq;
  logic [31:0] code;
  logic        busy;
  logic        done;
  logic        envelope;
  logic        irOut;
  logic [2:0]  state_dbg;

  int checks;
  int failures;

  logic [1:0] exp_q[$];

  ir_nec_transmitter #(
    .UNIT_CYCLES    (U),
    .CARRIER_PERIOD (CP),
    .CARRIER_HIGH   (CH)
  ) dut (
    .clk       (clk),
    .res       (res),
    .start     (start),
    .repeatReq (repeatReq),
    .code      (code),
    .busy      (busy),
    .done      (done),
    .envelope  (envelope),
    .irOut     (irOut),
    .state_dbg (state_dbg)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  task automatic add_seg(input bit level, input int len);
    for (int k = 0; k < len; k++) begin
      exp_q.push_back({level, level && ((k % CP) < CH)});
    end
  endtask

  task automatic build_expect(input bit rep, input logic [31:0] c);
    exp_q.delete();
    add_seg(1'b1, 16 * U);
    if (rep) begin
      add_seg(1'b0, 4 * U);
    end else begin
      add_seg(1'b0, 8 * U);
      for (int b = 0; b < 32; b++) begin
        add_seg(1'b1, U);
        add_seg(1'b0, c[b] ? 3 * U : U);
      end
    end
    add_seg(1'b1, U);
  endtask

  // ---------------- driver + per-frame checking ----------------
  // pre=1: the accepting edge has already happened (request was issued in
  // the previous done cycle). abort_at>=0: assert res at that frame cycle.
  task automatic run_frame(input string name, input bit rep, input logic [31:0] c,
                           input bit both, input bit pre, input int ign_a,
                           input int ign_b, input int abort_at,
                           input bit chain, input logic [31:0] next_code);
    int n;
    int wave_bad;
    int ctl_bad;
    int first_bad;
    logic [1:0] first_obs;
    logic [1:0] first_exp;
    build_expect(rep && !both, c);
    n = exp_q.size();
    wave_bad = 0;
    ctl_bad = 0;
    first_bad = -1;
    first_obs = 2'b00;
    first_exp = 2'b00;
    if (!pre) begin
      code = c;
      start = !rep || both;
      repeatReq = rep || both;
      @(negedge clk);
      start = 1'b0;
      repeatReq = 1'b0;
    end
    code = $urandom;
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s abort_busy got=%b exp=0", name, busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL %s abort_done got=%b exp=0", name, done); end
        checks++; if (envelope !== 1'b0) begin failures++; $display("FAIL %s abort_env got=%b exp=0", name, envelope); end
        checks++; if (irOut !== 1'b0) begin failures++; $display("FAIL %s abort_ir got=%b exp=0", name, irOut); end
        return;
      end
      if ({envelope, irOut} !== exp_q[i]) begin
        wave_bad++;
        if (first_bad < 0) begin
          first_bad = i;
          first_obs = {envelope, irOut};
          first_exp = exp_q[i];
        end
      end
      if (busy !== 1'b1 || done !== 1'b0) ctl_bad++;
      if (i == ign_a || i == ign_b) begin
        start = 1'b1;
        repeatReq = 1'(($urandom_range(0, 1)));
        code = $urandom;
      end else begin
        start = 1'b0;
        repeatReq = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (wave_bad !== 0) begin
      failures++;
      $display("FAIL %s wave: %0d bad cycles, first at %0d got env/ir=%b exp=%b",
               name, wave_bad, first_bad, first_obs, first_exp);
    end
    checks++;
    if (ctl_bad !== 0) begin
      failures++;
      $display("FAIL %s busy_done_in_frame: %0d bad cycles exp busy=1 done=0", name, ctl_bad);
    end
    // first cycle after the frame: the done cycle
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s end_busy got=%b exp=0 (len %0d)", name, busy, n); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL %s end_done got=%b exp=1", name, done); end
    checks++; if (envelope !== 1'b0) begin failures++; $display("FAIL %s end_env got=%b exp=0", name, envelope); end
    checks++; if (irOut !== 1'b0) begin failures++; $display("FAIL %s end_ir got=%b exp=0", name, irOut); end
    if (chain) begin
      code = next_code;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL %s chain_accept busy got=%b exp=1", name, busy); end
    end else begin
      @(negedge clk);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL %s done_width got=%b exp=0", name, done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s idle_busy got=%b exp=0", name, busy); end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    res = 1'b1;
    start = 1'b0;
    repeatReq = 1'b0;
    code = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (envelope !== 1'b0) begin failures++; $display("FAIL reset_env got=%b exp=0", envelope); end
    checks++; if (irOut !== 1'b0) begin failures++; $display("FAIL reset_ir got=%b exp=0", irOut); end
    res = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fixed_codes();
    run_frame("zeros", 1'b0, 32'h0000_0000, 1'b0, 1'b0, -1, -1, -1, 1'b0, '0);
    run_frame("ones",  1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, -1, -1, -1, 1'b0, '0);
    run_frame("lsb",   1'b0, 32'h0000_0001, 1'b0, 1'b0, -1, -1, -1, 1'b0, '0);
    run_frame("msb",   1'b0, 32'h8000_0000, 1'b0, 1'b0, -1, -1, -1, 1'b0, '0);
  endtask

  task automatic test_random_codes();
    for (int t = 0; t < 3; t++) begin
      run_frame("random", 1'b0, $urandom, 1'b0, 1'b0, -1, -1, -1, 1'b0, '0);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
  endtask

  task automatic test_repeat();
    run_frame("repeat", 1'b1, 32'h0, 1'b0, 1'b0, -1, -1, -1, 1'b0, '0);
  endtask

  task automatic test_priority();
    run_frame("start_and_repeat", 1'b1, 32'h0000_0000, 1'b1, 1'b0, -1, -1, -1, 1'b0, '0);
  endtask

  task automatic test_ignore_busy();
    run_frame("ignored_starts", 1'b0, 32'h0000_0000, 1'b0, 1'b0, 100, 500, -1, 1'b0, '0);
    run_frame("ignored_in_repeat", 1'b1, 32'h0, 1'b0, 1'b0, 30, 170, -1, 1'b0, '0);
  endtask

  task automatic test_mid_reset();
    run_frame("abort", 1'b0, $urandom, 1'b0, 1'b0, -1, -1, 300, 1'b0, '0);
    repeat (1) @(negedge clk);
    run_frame("after_abort", 1'b0, 32'h0000_0000, 1'b0, 1'b0, -1, -1, -1, 1'b0, '0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] c2;
    c2 = $urandom;
    run_frame("b2b_first", 1'b1, 32'h0, 1'b0, 1'b0, -1, -1, -1, 1'b1, c2);
    run_frame("b2b_second", 1'b0, c2, 1'b0, 1'b1, -1, -1, -1, 1'b0, '0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_fixed_codes();
    test_random_codes();
    test_repeat();
    test_priority();
    test_ignore_busy();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
